// File: rtl/seg_scan_ctrl_if.sv
// Bus bundle for the four-digit seven-segment scan controller: load side
// (data_in/dp_in/load) plus the pending/frame_tick status and the
// multiplexed digit/segment drive.
interface seg_scan_ctrl_if;
    logic [15:0] data_in;
    logic [3:0]  dp_in;
    logic        load;
    logic        pending;
    logic        frame_tick;
    logic [3:0]  dig_n;
    logic [6:0]  seg_n;
    logic        dp_n;

    modport master (
        output data_in, dp_in, load,
        input  pending, frame_tick, dig_n, seg_n, dp_n
    );

    modport slave (
        input  data_in, dp_in, load,
        output pending, frame_tick, dig_n, seg_n, dp_n
    );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Four-digit multiplexed seven-segment scan controller.
// Each digit slot opens with an all-off guard interval (anti-ghosting) and
// then drives one digit. New data is staged in a pending register and only
// copied into the displayed shadow at the frame boundary (idx 3 -> 0), so a
// frame never shows a mix of old and new values.
// Optional feature: define SEG_SCAN_BLANK_EN for leading-zero blanking of
// digits DIG_1..DIG_3 (DIG_4 is always driven).
module seg_scan_ctrl #(
    parameter int unsigned SCAN_DIV  = 12500,
    parameter int unsigned GUARD_CYC = 250
) (
    input  logic             FPGA_CLK,
    input  logic             RESET_BUT,
    seg_scan_ctrl_if.slave   bus
);

    localparam logic [15:0] GUARD_LAST = 16'(GUARD_CYC - 32'd1);
    localparam logic [15:0] SHOW_LAST  = 16'(SCAN_DIV - GUARD_CYC - 32'd1);

    typedef enum logic [0:0] {
        ST_GUARD = 1'b0,
        ST_SHOW  = 1'b1
    } state_t;

    state_t      state_r, state_nxt_s;
    logic [15:0] cnt_r, cnt_nxt_s;
    logic [1:0]  idx_r, idx_nxt_s;
    logic        wrap_s, tick_nxt_s;

    logic [15:0] shadow_r, shadow_nxt_s;
    logic [3:0]  sdp_r, sdp_nxt_s;
    logic [15:0] pdata_r, pdata_nxt_s;
    logic [3:0]  pdp_r, pdp_nxt_s;
    logic        pending_r, pending_nxt_s;

    logic [3:0]  nib_s;
    logic        dpb_s;
    logic [3:0]  dig_sel_s;
    logic        blank_s;
    logic [3:0]  dig_nxt_s;
    logic [6:0]  seg_nxt_s;
    logic        dp_nxt_s;

    logic [3:0]  dig_n_r;
    logic [6:0]  seg_n_r;
    logic        dp_n_r;
    logic        frame_tick_r;

    // Hex nibble to active-low segments, bit 6 = a ... bit 0 = g.
    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'h01;
            4'h1:    seg = 7'h4F;
            4'h2:    seg = 7'h12;
            4'h3:    seg = 7'h06;
            4'h4:    seg = 7'h4C;
            4'h5:    seg = 7'h24;
            4'h6:    seg = 7'h20;
            4'h7:    seg = 7'h0F;
            4'h8:    seg = 7'h00;
            4'h9:    seg = 7'h04;
            4'hA:    seg = 7'h08;
            4'hB:    seg = 7'h60;
            4'hC:    seg = 7'h31;
            4'hD:    seg = 7'h42;
            4'hE:    seg = 7'h30;
            4'hF:    seg = 7'h38;
            default: seg = 7'h7F;
        endcase
        return seg;
    endfunction

    // Slot FSM: guard/show sequencing, slot counter and digit index advance.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        idx_nxt_s   = idx_r;
        wrap_s      = 1'b0;
        case (state_r)
            ST_GUARD: begin
                if (cnt_r == GUARD_LAST) begin
                    state_nxt_s = ST_SHOW;
                    cnt_nxt_s   = 16'd0;
                end else begin
                    cnt_nxt_s   = cnt_r + 16'd1;
                end
            end
            ST_SHOW: begin
                if (cnt_r == SHOW_LAST) begin
                    state_nxt_s = ST_GUARD;
                    cnt_nxt_s   = 16'd0;
                    idx_nxt_s   = idx_r + 2'd1;
                    wrap_s      = (idx_r == 2'd3);
                end else begin
                    cnt_nxt_s   = cnt_r + 16'd1;
                end
            end
            default: begin
                state_nxt_s = ST_GUARD;
                cnt_nxt_s   = 16'd0;
                idx_nxt_s   = 2'd0;
            end
        endcase
        // frame_tick is high during the final show cycle of idx 3, i.e. the
        // cycle whose closing edge is the frame boundary.
        tick_nxt_s = (state_nxt_s == ST_SHOW) && (idx_nxt_s == 2'd3) &&
                     (cnt_nxt_s == SHOW_LAST);
    end

    // Load staging and boundary transfer; a load on the boundary goes straight to the shadow.
    always_comb begin
        shadow_nxt_s  = shadow_r;
        sdp_nxt_s     = sdp_r;
        pdata_nxt_s   = pdata_r;
        pdp_nxt_s     = pdp_r;
        pending_nxt_s = pending_r;
        if (wrap_s) begin
            pending_nxt_s = 1'b0;
            if (bus.load) begin
                shadow_nxt_s = bus.data_in;
                sdp_nxt_s    = bus.dp_in;
            end else if (pending_r) begin
                shadow_nxt_s = pdata_r;
                sdp_nxt_s    = pdp_r;
            end else begin
                shadow_nxt_s = shadow_r;
                sdp_nxt_s    = sdp_r;
            end
        end else if (bus.load) begin
            pdata_nxt_s   = bus.data_in;
            pdp_nxt_s     = bus.dp_in;
            pending_nxt_s = 1'b1;
        end else begin
            pending_nxt_s = pending_r;
        end
    end

    // Select the nibble, decimal point and digit enable for the upcoming slot.
    always_comb begin
        case (idx_nxt_s)
            2'd0: begin
                nib_s = shadow_nxt_s[15:12]; dpb_s = sdp_nxt_s[3]; dig_sel_s = 4'b0111;
            end
            2'd1: begin
                nib_s = shadow_nxt_s[11:8];  dpb_s = sdp_nxt_s[2]; dig_sel_s = 4'b1011;
            end
            2'd2: begin
                nib_s = shadow_nxt_s[7:4];   dpb_s = sdp_nxt_s[1]; dig_sel_s = 4'b1101;
            end
            2'd3: begin
                nib_s = shadow_nxt_s[3:0];   dpb_s = sdp_nxt_s[0]; dig_sel_s = 4'b1110;
            end
            default: begin
                nib_s = 4'h0;                dpb_s = 1'b0;         dig_sel_s = 4'b1111;
            end
        endcase
    end

    // Leading-zero blanking: a digit goes dark while it and everything to its left is zero.
    always_comb begin
`ifdef SEG_SCAN_BLANK_EN
        case (idx_nxt_s)
            2'd0:    blank_s = (shadow_nxt_s[15:12] == 4'h0);
            2'd1:    blank_s = (shadow_nxt_s[15:8]  == 8'h00);
            2'd2:    blank_s = (shadow_nxt_s[15:4]  == 12'h000);
            default: blank_s = 1'b0;
        endcase
`else
        blank_s = 1'b0;
`endif
    end

    // Next output drive, taken from next state so a slot change shows on the same edge.
    always_comb begin
        if ((state_nxt_s == ST_SHOW) && !blank_s) begin
            dig_nxt_s = dig_sel_s;
            seg_nxt_s = seg_decode(nib_s);
            dp_nxt_s  = ~dpb_s;
        end else begin
            dig_nxt_s = 4'hF;
            seg_nxt_s = 7'h7F;
            dp_nxt_s  = 1'b1;
        end
    end

    // State, data and output registers with synchronous active-low reset.
    always_ff @(posedge FPGA_CLK) begin
        if (!RESET_BUT) begin
            state_r      <= ST_GUARD;
            cnt_r        <= 16'd0;
            idx_r        <= 2'd0;
            shadow_r     <= 16'h0000;
            sdp_r        <= 4'h0;
            pdata_r      <= 16'h0000;
            pdp_r        <= 4'h0;
            pending_r    <= 1'b0;
            frame_tick_r <= 1'b0;
            dig_n_r      <= 4'hF;
            seg_n_r      <= 7'h7F;
            dp_n_r       <= 1'b1;
        end else begin
            state_r      <= state_nxt_s;
            cnt_r        <= cnt_nxt_s;
            idx_r        <= idx_nxt_s;
            shadow_r     <= shadow_nxt_s;
            sdp_r        <= sdp_nxt_s;
            pdata_r      <= pdata_nxt_s;
            pdp_r        <= pdp_nxt_s;
            pending_r    <= pending_nxt_s;
            frame_tick_r <= tick_nxt_s;
            dig_n_r      <= dig_nxt_s;
            seg_n_r      <= seg_nxt_s;
            dp_n_r       <= dp_nxt_s;
        end
    end

    assign bus.pending    = pending_r;
    assign bus.frame_tick = frame_tick_r;
    assign bus.dig_n      = dig_n_r;
    assign bus.seg_n      = seg_n_r;
    assign bus.dp_n       = dp_n_r;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with SCAN_DIV=8, GUARD_CYC=2
// (2 guard + 6 show cycles per slot, 32-cycle frame). Outputs are sampled
// on the falling edge; each sample packs {pending, frame_tick, dig_n,
// seg_n, dp_n} into one compared vector.
module tb_seg_scan_ctrl;

`ifdef SEG_SCAN_BLANK_EN
    localparam bit BLANK_EN = 1'b1;
`else
    localparam bit BLANK_EN = 1'b0;
`endif

    logic FPGA_CLK;
    logic RESET_BUT;
    int   n_pass;
    int   n_fail;
    int   n_total;

    int          ip[3];
    logic [15:0] idat[3];
    logic [3:0]  idp[3];
    logic [3:0]  dig_tab[4];

    seg_scan_ctrl_if bus ();

    seg_scan_ctrl #(
        .SCAN_DIV  (8),
        .GUARD_CYC (2)
    ) dut (
        .FPGA_CLK  (FPGA_CLK),
        .RESET_BUT (RESET_BUT),
        .bus       (bus)
    );

    initial begin
        FPGA_CLK = 1'b0;
        forever #5 FPGA_CLK = ~FPGA_CLK;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_total++;
        assert (obs === exp_v) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [31:0] outv();
        return 32'({bus.pending, bus.frame_tick, bus.dig_n, bus.seg_n, bus.dp_n});
    endfunction

    function automatic logic [31:0] mk(input logic p, input logic t, input logic [3:0] d,
                                       input logic [6:0] s, input logic dp);
        return 32'({p, t, d, s, dp});
    endfunction

    task automatic wait_tick(input string tag, input int budget);
        bit found;
        found = 1'b0;
        for (int i = 0; i < budget && !found; i++) begin
            @(negedge FPGA_CLK);
            bus.load = 1'b0;
            if (bus.frame_tick === 1'b1) found = 1'b1;
        end
        check(tag, 32'(found), 32'd1);
    endtask

    // Walk one full frame starting right after a frame_tick sample.
    // dpx/blk: bit (3-slot) set means dp lit / digit dark for that slot.
    // ip/idat/idp: loads injected after sampling the given frame positions.
    task automatic check_frame(input string tag, input logic [6:0] e0, input logic [6:0] e1,
                               input logic [6:0] e2, input logic [6:0] e3,
                               input logic [3:0] dpx, input logic [3:0] blk);
        logic [6:0]  es;
        logic        pe;
        logic        te;
        int          pos;
        logic [31:0] exp_v;
        for (int s = 0; s < 4; s++) begin
            for (int c = 0; c < 8; c++) begin
                pos = s * 8 + c;
                @(negedge FPGA_CLK);
                bus.load = 1'b0;
                case (s)
                    0:       es = e0;
                    1:       es = e1;
                    2:       es = e2;
                    default: es = e3;
                endcase
                pe = 1'b0;
                for (int j = 0; j < 3; j++) begin
                    if (ip[j] >= 0 && ip[j] < 31 && pos > ip[j]) pe = 1'b1;
                end
                te = (s == 3) && (c == 7);
                if (c < 2 || blk[3-s])
                    exp_v = mk(pe, te, 4'hF, 7'h7F, 1'b1);
                else
                    exp_v = mk(pe, te, dig_tab[s], es, ~dpx[3-s]);
                check($sformatf("%s_s%0d_c%0d", tag, s, c), outv(), exp_v);
                for (int j = 0; j < 3; j++) begin
                    if (ip[j] == pos) begin
                        bus.load    = 1'b1;
                        bus.data_in = idat[j];
                        bus.dp_in   = idp[j];
                    end
                end
            end
        end
        for (int j = 0; j < 3; j++) ip[j] = -1;
    endtask

    initial begin
        n_pass = 0; n_fail = 0; n_total = 0;
        dig_tab[0] = 4'h7; dig_tab[1] = 4'hB; dig_tab[2] = 4'hD; dig_tab[3] = 4'hE;
        for (int j = 0; j < 3; j++) begin
            ip[j] = -1; idat[j] = 16'h0000; idp[j] = 4'h0;
        end
        RESET_BUT   = 1'b0;
        bus.load    = 1'b1;
        bus.data_in = 16'hBEEF;
        bus.dp_in   = 4'hF;

        // Reset state (load held high during reset must be ignored)
        repeat (3) @(negedge FPGA_CLK);
        check("reset_out", outv(), mk(1'b0, 1'b0, 4'hF, 7'h7F, 1'b1));
        bus.load  = 1'b0;
        RESET_BUT = 1'b1;

        // First SHOW of idx 0 starts GUARD_CYC cycles after release, shadow is 0
        @(negedge FPGA_CLK);
        check("rel_guard", outv(), mk(1'b0, 1'b0, 4'hF, 7'h7F, 1'b1));
        @(negedge FPGA_CLK);
        if (BLANK_EN) check("rel_show0", outv(), mk(1'b0, 1'b0, 4'hF, 7'h7F, 1'b1));
        else          check("rel_show0", outv(), mk(1'b0, 1'b0, 4'h7, 7'h01, 1'b1));

        // Load 1234: stays pending until the boundary, current frame keeps 0000
        bus.load = 1'b1; bus.data_in = 16'h1234; bus.dp_in = 4'h0;
        @(negedge FPGA_CLK);
        bus.load = 1'b0;
        check("pend_set", 32'(bus.pending), 32'd1);
        wait_tick("tick_wait", 64);
        check("pre_tick", outv(), mk(1'b1, 1'b1, 4'hE, 7'h01, 1'b1));

        // Frame 1: 1234, with FFFF loaded while idx 1 is showing
        ip[0] = 12; idat[0] = 16'hFFFF; idp[0] = 4'h0;
        check_frame("f1234", 7'h4F, 7'h12, 7'h06, 7'h4C, 4'b0000, 4'b0000);

        // Frame 2: FFFF; 1111 then 2222 mid-frame, 5555 on the frame_tick cycle
        ip[0] = 3;  idat[0] = 16'h1111; idp[0] = 4'h0;
        ip[1] = 20; idat[1] = 16'h2222; idp[1] = 4'h0;
        ip[2] = 31; idat[2] = 16'h5555; idp[2] = 4'h0;
        check_frame("fFFFF", 7'h38, 7'h38, 7'h38, 7'h38, 4'b0000, 4'b0000);

        // Frame 3: 5555 (2222 skipped), pending clear; load 00A0
        ip[0] = 5; idat[0] = 16'h00A0; idp[0] = 4'h0;
        check_frame("f5555", 7'h24, 7'h24, 7'h24, 7'h24, 4'b0000, 4'b0000);

        // Frame 4: 00A0 (leading zeros dark when blanking is built in); load 1234 dp=0100
        ip[0] = 20; idat[0] = 16'h1234; idp[0] = 4'b0100;
        if (BLANK_EN)
            check_frame("f00A0", 7'h01, 7'h01, 7'h08, 7'h01, 4'b0000, 4'b1100);
        else
            check_frame("f00A0", 7'h01, 7'h01, 7'h08, 7'h01, 4'b0000, 4'b0000);

        // Frame 5: 1234 with decimal point only on DIG_2
        check_frame("fdp", 7'h4F, 7'h12, 7'h06, 7'h4C, 4'b0100, 4'b0000);

        // Reset during SHOW of idx 2
        repeat (20) @(negedge FPGA_CLK);
        check("pre_rst_idx2", outv(), mk(1'b0, 1'b0, 4'hD, 7'h06, 1'b1));
        RESET_BUT = 1'b0;
        @(negedge FPGA_CLK);
        check("mid_rst", outv(), mk(1'b0, 1'b0, 4'hF, 7'h7F, 1'b1));
        RESET_BUT = 1'b1;
        @(negedge FPGA_CLK);
        check("rst2_guard", outv(), mk(1'b0, 1'b0, 4'hF, 7'h7F, 1'b1));
        @(negedge FPGA_CLK);
        if (BLANK_EN) check("rst2_shadow0", outv(), mk(1'b0, 1'b0, 4'hF, 7'h7F, 1'b1));
        else          check("rst2_shadow0", outv(), mk(1'b0, 1'b0, 4'h7, 7'h01, 1'b1));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 Parameter SCAN_DIV, default 12500, FPGA_CLK cycles per digit slot; 4 kHz slot rate and 1 kHz frame rate at 50 MHz.
REQ-002 Parameter GUARD_CYC, default 250, all-off cycles at the start of each slot, for anti-ghosting.
REQ-003 FPGA_CLK  input  1  50 MHz system clock; sole clock.
REQ-004 RESET_BUT  input  1  reset; synchronous, active-low.
REQ-005 data_in  input  16  four hex nibbles; [15:12] shows on DIG_1 (leftmost), [3:0] on DIG_4.
REQ-006 dp_in  input  4  decimal point request per digit; bit 3 maps to DIG_1, bit 0 to DIG_4.
REQ-007 load  input  1  one-cycle strobe that captures data_in and dp_in.
REQ-008 pending  output  1  high while captured data awaits the frame boundary.
REQ-009 frame_tick  output  1  one-cycle pulse at each frame boundary.
REQ-010 dig_n  output  4  active-low digit enables; bit 3 drives DIG_1, bit 0 drives DIG_4.
REQ-011 seg_n  output  7  active-low segments, bit 6 = a through bit 0 = g.
REQ-012 dp_n  output  1  active-low decimal point.

Function
REQ-013 The block SHALL time-share the seg_n/dp_n bus among four digits using slot index idx (0..3); idx 0 selects DIG_1.
REQ-014 Each slot SHALL be an FSM with two states:
  - GUARD: GUARD_CYC cycles; dig_n=4'hF, seg_n=7'h7F, dp_n=1.
  - SHOW: SCAN_DIV-GUARD_CYC cycles; exactly one dig_n bit is low, for the digit at idx.
REQ-015 SHOW->GUARD SHALL advance idx modulo 4 (3 wraps to 0); the frame length is 4*SCAN_DIV cycles.
REQ-016 seg_n SHALL decode the shadow nibble at idx as follows:
  - 0=01, 1=4F, 2=12, 3=06, 4=4C, 5=24, 6=20, 7=0F
  - 8=00, 9=04, A=08, B=60, C=31, D=42, E=30, F=38 (hex).
REQ-017 Outputs SHALL be registered, and a state or idx change SHALL be visible on dig_n/seg_n in the same cycle it takes effect.
REQ-018 load SHALL write data_in/dp_in into a pending register and set pending; if a second load arrives before the boundary, the last value SHALL win.
REQ-019 The frame boundary SHALL be the cycle where idx wraps 3->0. At the boundary:
  - frame_tick=1.
  - If pending=1, the shadow SHALL be updated from the pending register and pending cleared.
REQ-020 If load coincides with the boundary, the shadow SHALL take data_in/dp_in directly, and pending SHALL be 0 next cycle.
REQ-021 The displayed value SHALL never change mid-frame; the frame SHALL show no tearing.
REQ-022 Counters SHALL be 16 bits wide; the block SHALL support 2<=SCAN_DIV<=65535 and 1<=GUARD_CYC<SCAN_DIV.

Reset
REQ-023 While RESET_BUT=0 at a FPGA_CLK edge, the block SHALL load these values:
  - dig_n=4'hF, seg_n=7'h7F, dp_n=1.
  - pending=0, frame_tick=0.
  - shadow and pending registers=0.
  - idx=0, state GUARD, counter 0.
REQ-024 Reset asserted mid-SHOW SHALL blank all outputs on the next edge; no partial slot SHALL resume.
REQ-025 After release, the first SHOW (idx 0) SHALL begin GUARD_CYC cycles later.

Configuration
REQ-026 Macro SEG_SCAN_BLANK_EN: when defined, digits 0..2 SHALL be blanked while they and all digits to their left hold nibble 0.
  - In a blanked slot, dig_n=4'hF, seg_n=7'h7F, dp_n=1.
  - Digit 3 SHALL never be blanked.
REQ-027 Without SEG_SCAN_BLANK_EN, all four digits SHALL always be driven per REQ-016.

Verification (SCAN_DIV=8, GUARD_CYC=2)
REQ-028 Load 16'h1234 after reset, then wait for frame_tick:
  - dig_n SHALL cycle 7,B,D,E, 6 cycles each, separated by 2 cycles of F.
  - seg_n SHALL be 4F,12,06,4C.
REQ-029 Load 16'h00A0 with the macro defined:
  - DIG_1 and DIG_2 SHALL stay dark.
  - seg_n SHALL be 08 then 01.
  - Without the macro, DIG_1 and DIG_2 SHALL show 01.
REQ-030 While 1234 is displayed, load FFFF at idx=1:
  - Remaining slots SHALL still show 1234.
  - pending SHALL stay 1 until frame_tick.
  - The next frame SHALL show 38 on all four digits.
REQ-031 Load 1111 then 2222 within one frame, then load 5555 on the frame_tick cycle:
  - 2222 SHALL never be displayed.
  - The next frame SHALL show 5555.
  - pending SHALL be 0 one cycle after the boundary.
REQ-032 Assert RESET_BUT=0 during SHOW of idx 2 -> the next edge SHALL give dig_n=F, seg_n=7F, and a shadow of 0.
REQ-033 dp_in=4'b0100 -> dp_n=0 only during the SHOW of DIG_2.
